// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if
//   Bundles the I-cache, D-cache and memory-side signals of the shared
//   line-transfer port.
//   Requester side : i_read/i_addr/i_rdata/i_resp,
//                    d_read/d_write/d_addr/d_wdata/d_rdata/d_resp
//   Memory side    : m_read/m_write/m_addr/m_wdata/m_rdata/m_resp
//   Status         : busy
// Modports:
//   slave  - the arbiter's view (takes requests, drives the memory port)
//   master - the view of the environment (caches plus memory model)
interface cache_arbiter_if #(
  parameter int s_line = 256,
  parameter int s_addr = 32
);
  logic              i_read;
  logic [s_addr-1:0] i_addr;
  logic [s_line-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [s_addr-1:0] d_addr;
  logic [s_line-1:0] d_wdata;
  logic [s_line-1:0] d_rdata;
  logic              d_resp;
  logic              m_read;
  logic              m_write;
  logic [s_addr-1:0] m_addr;
  logic [s_line-1:0] m_wdata;
  logic [s_line-1:0] m_rdata;
  logic              m_resp;
  logic              busy;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_resp,
    output i_rdata, i_resp, d_rdata, d_resp, m_read, m_write, m_addr, m_wdata,
           busy
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, m_read, m_write, m_addr, m_wdata,
           busy
  );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares one physical-memory line port between the I-cache (reads only)
//   and the D-cache (reads and writebacks). One transaction at a time: the
//   winner's address (and writeback data) is latched in IDLE and held
//   stable for the whole SERVE state; the memory completion is routed back
//   as a one-cycle resp to the granted requester only.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - cache_arbiter_if.slave (requester, memory and busy signals)
// Configuration:
//   ARB_ROUND_ROBIN_EN - when defined, simultaneous I and D requests go to
//   the requester that did not win last time; otherwise D always wins.
module cache_arbiter #(
  parameter int s_line = 256,
  parameter int s_addr = 32
) (
  input  logic             clk,
  input  logic             rst,
  cache_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_SERVE = 2'd1,
    D_SERVE = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  state_t            state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic [s_addr-1:0] m_addr_q, m_addr_d;
  logic [s_line-1:0] m_wdata_q, m_wdata_d;
  logic              wr_q, wr_d;      // latched D op is a writeback

  logic i_pend;
  logic d_pend;
  logic pick_d;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    wr_d         = wr_q;

    i_pend = bus.i_read;
    d_pend = bus.d_read | bus.d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // A lone D request always wins; on a tie, D wins only if I went last.
    pick_d = d_pend & (~i_pend | (last_grant_q == GRANT_I));
`else
    pick_d = d_pend;
`endif

    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d      = D_SERVE;
          last_grant_d = GRANT_D;
          m_addr_d     = bus.d_addr;
          // read+write together is treated as a write
          wr_d         = bus.d_write;
          if (bus.d_write) begin
            m_wdata_d = bus.d_wdata;
          end
        end else if (i_pend) begin
          state_d      = I_SERVE;
          last_grant_d = GRANT_I;
          m_addr_d     = bus.i_addr;
          wr_d         = 1'b0;
        end
      end
      I_SERVE: begin
        if (bus.m_resp) begin
          state_d = IDLE;
        end
      end
      D_SERVE: begin
        if (bus.m_resp) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      wr_q         <= wr_d;
    end
  end

  // Strobes decode directly from the registered state, so they rise the
  // cycle after the grant and drop the cycle after resp or reset.
  assign bus.m_read  = (state_q == I_SERVE) | ((state_q == D_SERVE) & ~wr_q);
  assign bus.m_write = (state_q == D_SERVE) & wr_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.busy    = (state_q != IDLE);

  // A completion arriving together with reset belongs to a transaction
  // being abandoned, so it is not forwarded.
  assign bus.i_resp  = (state_q == I_SERVE) & bus.m_resp & ~rst;
  assign bus.d_resp  = (state_q == D_SERVE) & bus.m_resp & ~rst;

  assign bus.i_rdata = bus.m_rdata;
  assign bus.d_rdata = bus.m_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;
  localparam int s_line = 256;
  localparam int s_addr = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_arbiter_if #(.s_line(s_line), .s_addr(s_addr)) bus ();

  cache_arbiter #(.s_line(s_line), .s_addr(s_addr)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  bit log_en = 1'b0;
  logic [23:0] grant_log = '0;   // last three winners as ASCII 'D'/'I'

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 = nobody holds the port, 1 = I-cache, 2 = D-cache
  int                owner    = 0;
  logic [s_addr-1:0] exp_addr = '0;
  logic [s_line-1:0] exp_wdat = '0;
  bit                exp_wr   = 1'b0;
  bit                last_was_d = 1'b0;

  always @(negedge clk) begin
    bit e_mr, e_mw, e_ir, e_dr, want_d, want_i, give_d;
    e_mr = (owner == 1) || (owner == 2 && !exp_wr);
    e_mw = (owner == 2) && exp_wr;
    e_ir = (owner == 1) && bus.m_resp && !rst;
    e_dr = (owner == 2) && bus.m_resp && !rst;
    if (chk_en) begin
      chk("m_read",  {255'd0, bus.m_read},  {255'd0, e_mr});
      chk("m_write", {255'd0, bus.m_write}, {255'd0, e_mw});
      chk("busy",    {255'd0, bus.busy},    {255'd0, owner != 0});
      chk("i_resp",  {255'd0, bus.i_resp},  {255'd0, e_ir});
      chk("d_resp",  {255'd0, bus.d_resp},  {255'd0, e_dr});
      chk("m_addr",  {224'd0, bus.m_addr},  {224'd0, exp_addr});
      chk("m_wdata", bus.m_wdata, exp_wdat);
      chk("i_rdata", bus.i_rdata, bus.m_rdata);
      chk("d_rdata", bus.d_rdata, bus.m_rdata);
      if (e_ir) $display("txn I read  addr=%h", exp_addr);
      if (e_dr) $display("txn D %s addr=%h", exp_wr ? "write" : "read ", exp_addr);
    end
    if (!log_en) grant_log = '0;
    else if (e_dr) grant_log = {grant_log[15:0], 8'h44};
    else if (e_ir) grant_log = {grant_log[15:0], 8'h49};

    // next-cycle prediction
    want_d = bus.d_read || bus.d_write;
    want_i = bus.i_read;
`ifdef ARB_ROUND_ROBIN_EN
    give_d = want_d && (!want_i || !last_was_d);
`else
    give_d = want_d;
`endif
    if (rst) begin
      owner = 0; exp_addr = '0; exp_wdat = '0; exp_wr = 0; last_was_d = 0;
    end else if (owner != 0) begin
      if (bus.m_resp) owner = 0;
    end else if (give_d) begin
      owner = 2; exp_addr = bus.d_addr; exp_wr = bus.d_write; last_was_d = 1;
      if (bus.d_write) exp_wdat = bus.d_wdata;
    end else if (want_i) begin
      owner = 1; exp_addr = bus.i_addr; exp_wr = 0; last_was_d = 0;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [255:0] pat_a5, pat_12, pat_w;

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_12 = {8{32'h1234_5678}};
    pat_w  = {8{32'hDEAD_BEEF}};
    rst = 1'b1;
    bus.i_read = 0; bus.i_addr = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_rdata = '0; bus.m_resp = 0;
    step(1);
    chk_en = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst m_addr", {224'd0, bus.m_addr}, 256'd0);
    chk("rst busy", {255'd0, bus.busy}, 256'd0);
    step(1);

    // Lone I read, memory answers 5 cycles after m_read rises
    bus.i_read = 1; bus.i_addr = 32'h0000_1000;
    step(1);
    chk("t1 m_read", {255'd0, bus.m_read}, 256'd1);
    chk("t1 m_addr", {224'd0, bus.m_addr}, 256'h1000);
    step(5);
    bus.m_resp = 1; bus.m_rdata = pat_a5;
    #1;
    chk("t1 i_resp", {255'd0, bus.i_resp}, 256'd1);
    chk("t1 i_rdata", bus.i_rdata, pat_a5);
    chk("t1 d_resp", {255'd0, bus.d_resp}, 256'd0);
    step(1);
    bus.m_resp = 0; bus.i_read = 0;
    chk("t1 idle", {255'd0, bus.busy}, 256'd0);
    step(2);

    // D writeback, requester changes its data mid-transaction
    bus.d_write = 1; bus.d_addr = 32'h8000_0040; bus.d_wdata = pat_12;
    step(1);
    chk("t2 m_write", {255'd0, bus.m_write}, 256'd1);
    chk("t2 m_addr", {224'd0, bus.m_addr}, 256'h8000_0040);
    bus.d_wdata = pat_w;
    step(2);
    chk("t2 m_wdata held", bus.m_wdata, pat_12);
    bus.m_resp = 1;
    #1;
    chk("t2 d_resp", {255'd0, bus.d_resp}, 256'd1);
    chk("t2 m_wdata end", bus.m_wdata, pat_12);
    step(1);
    bus.m_resp = 0; bus.d_write = 0;
    step(2);

    // Simultaneous I and D reads, three rounds, both keep requesting
    log_en = 1'b1;
    bus.i_read = 1; bus.i_addr = 32'h0000_2000;
    bus.d_read = 1; bus.d_addr = 32'h0000_3000;
    for (int r = 0; r < 3; r++) begin
      step(1);
      step(2);
      bus.m_resp = 1;
      step(1);
      bus.m_resp = 0;
      if (r == 2) begin bus.i_read = 0; bus.d_read = 0; end
    end
    step(1);
`ifdef ARB_ROUND_ROBIN_EN
    chk("t3 grant order", {232'd0, grant_log}, {232'd0, "DID"});
`else
    chk("t3 grant order", {232'd0, grant_log}, {232'd0, "DDD"});
`endif
    log_en = 1'b0;
    step(2);

    // I request arriving while D is being served
    bus.d_read = 1; bus.d_addr = 32'h0000_0040;
    step(1);
    step(1);
    bus.i_read = 1; bus.i_addr = 32'h0000_5000;
    step(1);
    bus.m_resp = 1;
    step(1);
    bus.m_resp = 0; bus.d_read = 0;
    step(1);
    chk("t4 m_read at resp+2", {255'd0, bus.m_read}, 256'd1);
    chk("t4 m_addr", {224'd0, bus.m_addr}, 256'h5000);
    step(1);
    bus.m_resp = 1;
    step(1);
    bus.m_resp = 0; bus.i_read = 0;
    step(2);

    // Reset during I_SERVE; the late memory response must be dropped
    bus.i_read = 1; bus.i_addr = 32'h0000_6000;
    step(2);
    rst = 1;
    step(1);
    rst = 0; bus.i_read = 0;
    chk("t5 busy", {255'd0, bus.busy}, 256'd0);
    chk("t5 m_read", {255'd0, bus.m_read}, 256'd0);
    step(2);
    bus.m_resp = 1;
    #1;
    chk("t5 no i_resp", {255'd0, bus.i_resp}, 256'd0);
    step(1);
    bus.m_resp = 0;
    step(2);

    // Illegal read+write together is issued as a write
    bus.d_read = 1; bus.d_write = 1; bus.d_addr = 32'h0000_0100; bus.d_wdata = pat_w;
    step(1);
    chk("t6 m_write", {255'd0, bus.m_write}, 256'd1);
    chk("t6 m_read", {255'd0, bus.m_read}, 256'd0);
    chk("t6 m_wdata", bus.m_wdata, pat_w);
    step(1);
    bus.m_resp = 1;
    step(1);
    bus.m_resp = 0; bus.d_read = 0; bus.d_write = 0;
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates the single physical-memory port between the instruction-cache and data-cache miss/writeback paths of the pipelined processor. It sits between the two cache controllers, which sequence their tag/valid/dirty/data arrays, and the shared memory or L2 interface. It grants one 256-bit line transaction at a time, latches the winner's address and write data, and routes the memory response back to that requester only.

## Interface
Parameters:
- s_line, 256, cache line width in bits
- s_addr, 32, address width in bits

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_read  in  1  I-cache line read request, level, held until i_resp
- i_addr  in  s_addr  I-cache line address
- i_rdata  out  s_line  line data to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request, level, held until d_resp
- d_write  in  1  D-cache line writeback request, level, held until d_resp
- d_addr  in  s_addr  D-cache line address
- d_wdata  in  s_line  D-cache writeback data
- d_rdata  out  s_line  line data to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- m_read  out  1  memory read strobe
- m_write  out  1  memory write strobe
- m_addr  out  s_addr  memory address, registered
- m_wdata  out  s_line  memory write data, registered
- m_rdata  in  s_line  memory read data
- m_resp  in  1  memory completion pulse
- busy  out  1  high in any non-IDLE state

## Operation
- States: IDLE, I_SERVE, D_SERVE.
- IDLE: if any request is pending, grant per the priority rule and latch the winner's address into m_addr. For D writes, also latch d_wdata into m_wdata. Record the winner in last_grant and move to the matching SERVE state.
- Default priority: D over I.
- I_SERVE: m_read=1. On m_resp, pulse i_resp and return to IDLE.
- D_SERVE: if the latched op is a write, m_write=1; otherwise m_read=1. On m_resp, pulse d_resp and return to IDLE.
- d_read and d_write both high is illegal. The write wins, and the transaction is latched as a write.
- i_rdata and d_rdata are both driven from m_rdata at all times. Only the granted requester receives a resp.
- m_resp received in IDLE is ignored.
- Requester contract: deassert the request no later than the cycle after its resp. The arbiter spends at least one IDLE cycle between transactions.
- Requests arriving mid-transaction are held by the requester and evaluated at the next IDLE cycle.

## Timing
- Reset values: state=IDLE, m_read=0, m_write=0, m_addr=0, m_wdata=0, i_resp=0, d_resp=0, busy=0, last_grant=I.
- Request visible in IDLE at cycle N: m_read or m_write is high from cycle N+1 with the latched m_addr.
- resp to the requester is combinational with m_resp in the same cycle: exactly one cycle wide.
- Minimum turnaround: 1 IDLE cycle after resp. Back-to-back transactions therefore start at resp+2.
- m_addr and m_wdata are stable for the entire SERVE state, regardless of changes on the requester inputs.
- rst asserted mid-transaction: IDLE on the next cycle and strobes drop. The outstanding memory response is discarded and no resp is issued.

## Configuration
- ARB_ROUND_ROBIN_EN defined: when i and d requests are pending in the same IDLE cycle, the requester not in last_grant wins. A lone request always wins.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, D always beats I. last_grant is still maintained but unused.

## Test plan
- Lone I read: i_read=1, i_addr=0x0000_1000, memory returns m_resp 5 cycles after m_read with m_rdata=0xA5…A5. Required: m_read high from N+1, m_addr=0x1000, one i_resp pulse, i_rdata=0xA5…A5, d_resp never asserted.
- D writeback: d_write=1, d_addr=0x8000_0040, d_wdata=0x1234…; change d_wdata during D_SERVE. Required: m_write=1, and m_wdata holds the original value until m_resp.
- Simultaneous i_read and d_read, three rounds, each requester re-requesting immediately. Without the macro: D,D,D and I starved. With ARB_ROUND_ROBIN_EN: D,I,D (last_grant reset=I).
- I request arriving mid D_SERVE: granted in the IDLE cycle after d_resp. m_read is re-asserted at d_resp+2 with the I address.
- rst pulsed during I_SERVE before m_resp: next cycle state=IDLE and m_read=0. A later m_resp produces no i_resp.
- d_read=1 and d_write=1 together: a write is issued (m_write=1, m_read=0).
